// File: rtl/popcount25_tneuron_seq.sv
// ---------------------------------------------------------------------------
// popcount25_tneuron_seq
//
// Sequencer for one ternary neuron with fan-in 25*N_CHUNKS. A single shared
// 25-input popcount core is time-multiplexed: each chunk's positive mask and
// then its negative mask are sent through the core, and the two counts are
// accumulated separately. After the last chunk the neuron produces a ternary
// activation from the difference of the two sums, compared against a dead zone.
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   chunk valid
//   in_ready   chunk accepted when in_valid & in_ready (LOAD only)
//   in_pos     input bits with weight +1
//   in_neg     input bits with weight -1
//   cfg_thr    dead-zone threshold, captured with chunk 0
//   pc_in      registered vector presented to the shared popcount core
//   pc_cnt     combinational popcount of pc_in from the core (0..31)
//   out_valid  activation valid
//   out_ready  activation consumed when out_valid & out_ready
//   out_act    01 = +1, 11 = -1, 00 = 0
//   out_diff   signed acc_pos - acc_neg
//   busy       low only when idle in LOAD waiting for chunk 0
// ---------------------------------------------------------------------------
module popcount25_tneuron_seq #(
    parameter int N_CHUNKS = 4,
    parameter int ACC_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [24:0]        in_pos,
    input  logic [24:0]        in_neg,
    input  logic [ACC_W-1:0]   cfg_thr,
    output logic [24:0]        pc_in,
    input  logic [4:0]         pc_cnt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         out_act,
    output logic signed [ACC_W:0] out_diff,
    output logic               busy
);

    localparam int CNT_W = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    // Wide enough to hold acc + pc_cnt without wrapping, even for small ACC_W.
    localparam int SUM_W = ((ACC_W > 5) ? ACC_W : 5) + 1;

    localparam logic [ACC_W-1:0] ACC_MAX    = '1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(N_CHUNKS - 1);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_POS  = 2'd1,
        S_NEG  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t             state_q,     state_d;
    logic [CNT_W-1:0]   chunk_cnt_q, chunk_cnt_d;
    logic [ACC_W-1:0]   acc_pos_q,   acc_pos_d;
    logic [ACC_W-1:0]   acc_neg_q,   acc_neg_d;
    logic [ACC_W-1:0]   thr_q,       thr_d;
    logic [24:0]        pos_q,       pos_d;
    logic [24:0]        neg_q,       neg_d;
    logic [24:0]        pc_in_q,     pc_in_d;

    // Saturating accumulate; pc_cnt above 25 is taken at face value.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                                 input logic [4:0]       cnt);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(acc) + SUM_W'(cnt);
        return (sum > SUM_W'(ACC_MAX)) ? ACC_MAX : sum[ACC_W-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        chunk_cnt_d = chunk_cnt_q;
        acc_pos_d   = acc_pos_q;
        acc_neg_d   = acc_neg_q;
        thr_d       = thr_q;
        pos_d       = pos_q;
        neg_d       = neg_q;
        pc_in_d     = pc_in_q;
        in_ready    = 1'b0;

        unique case (state_q)
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    pos_d   = in_pos;
                    neg_d   = in_neg;
                    // pc_in is registered, so load it on the way into POS.
                    pc_in_d = in_pos;
                    state_d = S_POS;
                    if (chunk_cnt_q == '0) begin
                        acc_pos_d = '0;
                        acc_neg_d = '0;
                        thr_d     = cfg_thr;
                    end
                end
            end
            S_POS: begin
                acc_pos_d = sat_add(acc_pos_q, pc_cnt);
                pc_in_d   = neg_q;
                state_d   = S_NEG;
            end
            S_NEG: begin
                acc_neg_d = sat_add(acc_neg_q, pc_cnt);
                pc_in_d   = '0;
                if (chunk_cnt_q == LAST_CHUNK) begin
                    chunk_cnt_d = '0;
                    state_d     = S_OUT;
                end else begin
                    chunk_cnt_d = chunk_cnt_q + CNT_W'(1);
                    state_d     = S_LOAD;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_LOAD;
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers (synchronous reset aborts any evaluation in flight)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the values
        // from before this edge, independent of statement order.
        if (!rst_n) begin
            state_q     <= S_LOAD;
            chunk_cnt_q <= '0;
            acc_pos_q   <= '0;
            acc_neg_q   <= '0;
            thr_q       <= '0;
            pos_q       <= '0;
            neg_q       <= '0;
            pc_in_q     <= '0;
        end else begin
            state_q     <= state_d;
            chunk_cnt_q <= chunk_cnt_d;
            acc_pos_q   <= acc_pos_d;
            acc_neg_q   <= acc_neg_d;
            thr_q       <= thr_d;
            pos_q       <= pos_d;
            neg_q       <= neg_d;
            pc_in_q     <= pc_in_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all derived from registers, so they hold steady in OUT.
    // ------------------------------------------------------------------
    logic signed [ACC_W+1:0] diff_ext;
    logic signed [ACC_W+1:0] thr_ext;

    assign pc_in     = pc_in_q;
    assign out_valid = (state_q == S_OUT);
    assign busy      = !((state_q == S_LOAD) && (chunk_cnt_q == '0));
    assign out_diff  = $signed({1'b0, acc_pos_q}) - $signed({1'b0, acc_neg_q});

    // One extra bit so -thr_q cannot overflow the comparison.
    assign diff_ext  = {out_diff[ACC_W], out_diff};
    assign thr_ext   = {2'b00, thr_q};

    always_comb begin
        out_act = 2'b00;
        if (diff_ext > thr_ext) begin
            out_act = 2'b01;
        end else if (diff_ext < -thr_ext) begin
            out_act = 2'b11;
        end
    end

endmodule

// File: tb/tb_popcount25_tneuron_seq.sv
// ---------------------------------------------------------------------------
// tb_popcount25_tneuron_seq
//
// Self-checking bench for popcount25_tneuron_seq (N_CHUNKS=4). A second
// instance with ACC_W=6 runs in lockstep on the same inputs with a core that
// reports 31 for any non-zero vector, to exercise accumulator saturation.
// ---------------------------------------------------------------------------
module tb_popcount25_tneuron_seq;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [24:0]        in_pos;
    logic [24:0]        in_neg;
    logic [7:0]         cfg_thr;
    logic [24:0]        pc_in;
    logic [4:0]         pc_cnt;
    logic               out_valid;
    logic               out_ready;
    logic [1:0]         out_act;
    logic signed [8:0]  out_diff;
    logic               busy;

    logic               in_ready2;
    logic [24:0]        pc_in2;
    logic [4:0]         pc_cnt2;
    logic               out_valid2;
    logic [1:0]         out_act2;
    logic signed [6:0]  out_diff2;
    logic               busy2;

    int core_mode = 0;   // 0: exact popcount, 1: approximate (can exceed 25)
    int n_checks  = 0;
    int n_pass    = 0;
    int cyc       = 0;

    always #5 clk = ~clk;

    popcount25_tneuron_seq #(.N_CHUNKS(4), .ACC_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pos(in_pos), .in_neg(in_neg), .cfg_thr(cfg_thr),
        .pc_in(pc_in), .pc_cnt(pc_cnt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_act(out_act), .out_diff(out_diff), .busy(busy)
    );

    popcount25_tneuron_seq #(.N_CHUNKS(4), .ACC_W(6)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_pos(in_pos), .in_neg(in_neg), .cfg_thr(cfg_thr[5:0]),
        .pc_in(pc_in2), .pc_cnt(pc_cnt2),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_act(out_act2), .out_diff(out_diff2), .busy(busy2)
    );

    // ---------------- environment: popcount cores ----------------
    function automatic int core_fn(input logic [24:0] m, input int md);
        int c;
        c = $countones(m);
        if (md == 1 && c != 0) c = (c + 6 > 31) ? 31 : c + 6;
        return c;
    endfunction

    always_comb pc_cnt  = 5'(core_fn(pc_in, core_mode));
    always_comb pc_cnt2 = (pc_in2 != '0) ? 5'd31 : 5'd0;

    // ---------------- reference model ----------------
    // Whole-evaluation view: sum counts with clamping, subtract, classify.
    function automatic void model(input logic [3:0][24:0] pos,
                                  input logic [3:0][24:0] neg,
                                  input int thr, input int md,
                                  output int e_diff, output int e_act);
        int ap, an;
        ap = 0; an = 0;
        for (int k = 0; k < 4; k++) begin
            ap = ap + core_fn(pos[k], md); if (ap > 255) ap = 255;
            an = an + core_fn(neg[k], md); if (an > 255) an = 255;
        end
        e_diff = ap - an;
        if (e_diff > thr)       e_act = 1;
        else if (e_diff < -thr) e_act = 3;
        else                    e_act = 0;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_eval(input string name,
                            input logic [3:0][24:0] pos, input logic [3:0][24:0] neg,
                            input int thr, input int gap, input int hold,
                            input int e_diff, input int e_act,
                            input bit chk_lat, input bit chk_sat);
        int t0, t;
        t0 = 0;
        for (int k = 0; k < 4; k++) begin
            repeat (gap) begin in_valid = 1'b0; step(); end
            t = 0;
            while (!in_ready && t < 50) begin
                in_valid = 1'($urandom); in_pos = 25'($urandom); in_neg = 25'($urandom);
                step(); t++;
            end
            if (!in_ready) begin
                check({name, " in_ready timeout"}, 0, 1);
                return;
            end
            in_valid = 1'b1; in_pos = pos[k]; in_neg = neg[k];
            cfg_thr  = (k == 0) ? 8'(thr) : 8'($urandom);
            if (k == 0) t0 = cyc;
            step();
            // Scramble inputs while the chunk is in flight.
            in_valid = 1'($urandom); in_pos = 25'($urandom);
            in_neg   = 25'($urandom); cfg_thr = 8'($urandom);
            check({name, " pc_in pos"}, int'(pc_in), int'(pos[k]));
            step();
            check({name, " pc_in neg"}, int'(pc_in), int'(neg[k]));
            step();
        end
        t = 0;
        while (!out_valid && t < 50) begin step(); t++; end
        check({name, " out_valid"}, int'(out_valid), 1);
        if (chk_lat) check({name, " latency"}, cyc - t0, 12);
        check({name, " out_diff"}, int'(out_diff), e_diff);
        check({name, " out_act"}, int'(out_act), e_act);
        check({name, " in_ready in OUT"}, int'(in_ready), 0);
        check({name, " pc_in in OUT"}, int'(pc_in), 0);
        if (chk_sat) begin
            check({name, " sat out_diff"}, int'(out_diff2), 63);
            check({name, " sat out_act"}, int'(out_act2), 1);
        end
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1; in_pos = 25'($urandom); in_neg = 25'($urandom);
            step();
            check({name, " hold stable"},
                  int'({out_valid, in_ready, out_act, out_diff}),
                  int'({1'b1, 1'b0, 2'(e_act), 9'(e_diff)}));
        end
        // Consume with a chunk pending: it must not be taken in this edge.
        in_valid = 1'b1; in_pos = 25'($urandom); in_neg = 25'($urandom);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({name, " post-consume state"},
              int'({out_valid, in_ready, busy}), int'({1'b0, 1'b1, 1'b0}));
    endtask

    // ---------------- table ----------------
    typedef struct {
        string              name;
        logic [3:0][24:0]   pos;
        logic [3:0][24:0]   neg;
        int                 thr;
        int                 hold;
        int                 e_diff;
        int                 e_act;
        bit                 chk_lat;
        bit                 chk_sat;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0][24:0] rp, rn;
        int rthr, ed, ea;

        tbl[0] = '{"all_ones", {4{25'h1FFFFFF}}, '0, 0, 0, 100, 1, 1'b1, 1'b1};
        tbl[1] = '{"balanced", {4{25'h0F0F0F0}}, {4{25'h0F0F0F0}}, 0, 0, 0, 0, 1'b1, 1'b0};
        tbl[2] = '{"neg6_thr5", '0, {75'h0, 25'h3F}, 5, 0, -6, 3, 1'b0, 1'b0};
        tbl[3] = '{"neg5_thr5", '0, {75'h0, 25'h1F}, 5, 0, -5, 0, 1'b0, 1'b0};
        tbl[4] = '{"pos6_thr5", {75'h0, 25'h3F}, '0, 5, 0, 6, 1, 1'b0, 1'b0};
        tbl[5] = '{"pos5_thr5", {75'h0, 25'h1F}, '0, 5, 0, 5, 0, 1'b0, 1'b0};
        tbl[6] = '{"hold10", {25'h0000FFF, 25'h1, 25'h3, 25'h7},
                   {25'h1, 25'h0, 25'h0, 25'h10000}, 3, 10, 16, 1, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_pos = '0; in_neg = '0;
        cfg_thr = '0; out_ready = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        check("reset out_valid", int'(out_valid), 0);
        check("reset in_ready", int'(in_ready), 1);
        check("reset busy", int'(busy), 0);
        check("reset pc_in", int'(pc_in), 0);
        check("reset out_diff", int'(out_diff), 0);

        for (int i = 0; i < 7; i++)
            run_eval(tbl[i].name, tbl[i].pos, tbl[i].neg, tbl[i].thr, 0, tbl[i].hold,
                     tbl[i].e_diff, tbl[i].e_act, tbl[i].chk_lat, tbl[i].chk_sat);

        // Reset during NEG of chunk 2 discards the partial sums.
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_pos = 25'h00000FF; in_neg = 25'h0000001; cfg_thr = 8'd2;
            step();
            in_valid = 1'b0;
            step();
            if (k < 2) step();
        end
        check("mid-run busy", int'(busy), 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("abort state", int'({out_valid, in_ready, busy}), int'({1'b0, 1'b1, 1'b0}));
        check("abort out_diff", int'(out_diff), 0);
        check("abort pc_in", int'(pc_in), 0);
        for (int k = 0; k < 4; k++) begin
            rp[k] = 25'($urandom); rn[k] = 25'($urandom) & 25'($urandom);
        end
        model(rp, rn, 7, 0, ed, ea);
        run_eval("after_abort", rp, rn, 7, 0, 0, ed, ea, 1'b1, 1'b0);

        // Randomized evaluations against the model, both core modes.
        for (int i = 0; i < 25; i++) begin
            core_mode = int'($urandom_range(0, 1));
            for (int k = 0; k < 4; k++) begin
                rp[k] = 25'($urandom);
                rn[k] = 25'($urandom);
                if ($urandom_range(0, 1) == 1) rp[k] = rp[k] & 25'($urandom);
                if ($urandom_range(0, 1) == 1) rn[k] = rn[k] & 25'($urandom);
            end
            rthr = int'($urandom_range(0, 40));
            model(rp, rn, rthr, core_mode, ed, ea);
            run_eval("random", rp, rn, rthr, int'($urandom_range(0, 2)),
                     int'($urandom_range(0, 3)), ed, ea, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
